// File: rtl/adat_pkg.sv
// Shared ADAT frame constants and sample/frame types for the transmit path.
package adat_pkg;

  localparam int unsigned ADAT_NUM_CH     = 8;
  localparam int unsigned ADAT_SAMPLE_W   = 24;
  localparam int unsigned ADAT_FRAME_CLKS = 2048;
  localparam int unsigned ADAT_CNT_W      = 16;

  typedef logic signed [ADAT_SAMPLE_W-1:0] adat_sample_t;
  typedef adat_sample_t [0:ADAT_NUM_CH-1]  adat_frame_t;

endpackage

// File: rtl/adat_frame_timer.sv
// Frame pacing timer for the ADAT transmitter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : run the timer; low holds the counter at 0
//   boundary_c   : combinational strobe, high on the last cycle of a frame
//   start        : registered frame-load pulse, one cycle after each boundary
module adat_frame_timer #(
  parameter int unsigned FRAME_CLKS = 2048
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic boundary_c,
  output logic start
);

  localparam int unsigned CW = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CLKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter advance and wrap; idle forces it back to 0
  always_comb begin
    cnt_d      = '0;
    boundary_c = enable && (cnt_q == LAST);
    if (enable && !boundary_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and start pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      start <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      start <= boundary_c;
    end
  end

endmodule

// File: rtl/adat_tx_frame_scheduler.sv
// Frame sequencer for the ADAT transmit serializer: collects per-channel samples
// into a fill buffer and swaps it into a held output frame at each frame boundary.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   enable                    : run frame timer; low = idle, buffers cleared
//   s_valid/s_ready           : sample write handshake
//   s_chan, s_data            : target channel and sample value
//   timecode, midi, smux      : user bits, sampled at each frame boundary
//   start                     : one-cycle frame-load pulse to the serializer
//   audio_out                 : held frame samples, channel 0 first
//   ub_timecode/ub_midi/ub_smux : held user bits for the current frame
//   underrun                  : pulse with start when the frame was incomplete
//   underrun_count            : saturating count of underruns
module adat_tx_frame_scheduler
  import adat_pkg::*;
#(
  parameter int unsigned NUM_CH     = ADAT_NUM_CH,
  parameter int unsigned SAMPLE_W   = ADAT_SAMPLE_W,
  parameter int unsigned FRAME_CLKS = ADAT_FRAME_CLKS,
  parameter int unsigned CNT_W      = ADAT_CNT_W,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [CH_W-1:0]                    s_chan,
  input  logic signed [SAMPLE_W-1:0]         s_data,
  input  logic                               timecode,
  input  logic                               midi,
  input  logic                               smux,
  output logic                               start,
  output logic [0:NUM_CH-1][SAMPLE_W-1:0]    audio_out,
  output logic                               ub_timecode,
  output logic                               ub_midi,
  output logic                               ub_smux,
  output logic                               underrun,
  output logic [CNT_W-1:0]                   underrun_count
);

  logic boundary_c;

  adat_frame_timer #(
    .FRAME_CLKS (FRAME_CLKS)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .boundary_c (boundary_c),
    .start      (start)
  );

  logic [0:NUM_CH-1][SAMPLE_W-1:0] fill_q;
  logic [0:NUM_CH-1][SAMPLE_W-1:0] fill_d;
  logic [NUM_CH-1:0]               mask_q;
  logic [NUM_CH-1:0]               mask_d;
  logic [0:NUM_CH-1][SAMPLE_W-1:0] audio_d;
  logic                            ub_timecode_d;
  logic                            ub_midi_d;
  logic                            ub_smux_d;
  logic                            underrun_d;
  logic [CNT_W-1:0]                count_d;

  logic mask_full_c;
  logic chan_ok_c;
  logic handshake_c;

  assign mask_full_c = &mask_q;
  // Out-of-range channels complete the handshake but are discarded
  assign chan_ok_c   = 32'(s_chan) < 32'(NUM_CH);
  // Gated by reset_n so the port reads 0 throughout reset even with enable high
  assign s_ready     = reset_n && enable && !mask_full_c;
  assign handshake_c = s_valid && s_ready;

  // Buffer swap, mute-on-underrun, user-bit capture and sample writes
  always_comb begin
    fill_d        = fill_q;
    mask_d        = mask_q;
    audio_d       = audio_out;
    ub_timecode_d = ub_timecode;
    ub_midi_d     = ub_midi;
    ub_smux_d     = ub_smux;
    underrun_d    = 1'b0;
    count_d       = underrun_count;

    if (!enable) begin
      fill_d = '0;
      mask_d = '0;
    end else begin
      if (boundary_c) begin
        ub_timecode_d = timecode;
        ub_midi_d     = midi;
        ub_smux_d     = smux;
        if (mask_full_c) begin
          audio_d = fill_q;
          mask_d  = '0;
        end else begin
          // Incomplete frame: mute, keep partial buffer for the next boundary
          audio_d    = '0;
          underrun_d = 1'b1;
          if (underrun_count != {CNT_W{1'b1}}) begin
            count_d = underrun_count + CNT_W'(1);
          end
        end
      end
      // s_ready is low whenever a full-mask swap happens, so no write can collide
      if (handshake_c && chan_ok_c) begin
        fill_d[s_chan] = s_data;
        mask_d[s_chan] = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q         <= '0;
      mask_q         <= '0;
      audio_out      <= '0;
      ub_timecode    <= 1'b0;
      ub_midi        <= 1'b0;
      ub_smux        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      fill_q         <= fill_d;
      mask_q         <= mask_d;
      audio_out      <= audio_d;
      ub_timecode    <= ub_timecode_d;
      ub_midi        <= ub_midi_d;
      ub_smux        <= ub_smux_d;
      underrun       <= underrun_d;
      underrun_count <= count_d;
    end
  end

endmodule

// File: tb/tb_adat_tx_frame_scheduler.sv
// Bench for adat_tx_frame_scheduler with a short frame and narrow counter.
module tb_adat_tx_frame_scheduler;

  localparam int unsigned NCH = 8;
  localparam int unsigned SW  = 24;
  localparam int unsigned FC  = 32;
  localparam int unsigned CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  typedef logic [0:NCH-1][SW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          s_valid;
  logic          s_ready;
  logic [2:0]    s_chan;
  logic [SW-1:0] s_data;
  logic          timecode, midi, smux;
  logic          start;
  frame_t        audio_out;
  logic          ub_timecode, ub_midi, ub_smux;
  logic          underrun;
  logic [CW-1:0] underrun_count;

  always #5 clk = ~clk;

  adat_tx_frame_scheduler #(
    .NUM_CH(NCH), .SAMPLE_W(SW), .FRAME_CLKS(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
    .timecode(timecode), .midi(midi), .smux(smux),
    .start(start), .audio_out(audio_out),
    .ub_timecode(ub_timecode), .ub_midi(ub_midi), .ub_smux(ub_smux),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: frame position, per-channel written flags and sample store
  int            pos;
  bit            written [NCH];
  logic [SW-1:0] fillm   [NCH];
  frame_t        m_audio;
  logic [2:0]    m_ub;
  bit            m_start, m_under;
  int            m_count;
  logic [2:0]    cur_ub;

  task automatic model_reset();
    pos = 0; m_audio = '0; m_ub = '0; m_start = 0; m_under = 0; m_count = 0;
    for (int c = 0; c < NCH; c++) begin written[c] = 0; fillm[c] = '0; end
  endtask

  function automatic bit all_written();
    bit r = 1;
    for (int c = 0; c < NCH; c++) r &= written[c];
    return r;
  endfunction

  // One clock cycle: drive inputs, check s_ready, advance model, check outputs
  task automatic step(input bit en, input bit v, input int ch, input logic [SW-1:0] d,
                      input logic [2:0] ub);
    bit rdy;
    @(negedge clk);
    enable = en; s_valid = v; s_chan = 3'(ch); s_data = d;
    {timecode, midi, smux} = ub;
    #1;
    rdy = en && !all_written();
    checks++;
    if (s_ready !== rdy) begin
      errors++; $display("FAIL s_ready t=%0t got=%b exp=%b", $time, s_ready, rdy);
    end
    if (!en) begin
      pos = 0; m_start = 0; m_under = 0;
      for (int c = 0; c < NCH; c++) begin written[c] = 0; fillm[c] = '0; end
    end else begin
      m_start = (pos == FC - 1);
      m_under = 0;
      if (m_start) begin
        m_ub = ub;
        if (all_written()) begin
          for (int c = 0; c < NCH; c++) begin m_audio[c] = fillm[c]; written[c] = 0; end
        end else begin
          m_audio = '0; m_under = 1;
          if (m_count < CMAX) m_count++;
        end
      end
      if (v && rdy) begin fillm[ch] = d; written[ch] = 1; end
      pos = (pos + 1) % FC;
    end
    @(posedge clk); #1;
    checks++;
    if (start !== m_start) begin
      errors++; $display("FAIL start t=%0t got=%b exp=%b", $time, start, m_start);
    end
    checks++;
    if (underrun !== m_under) begin
      errors++; $display("FAIL underrun t=%0t got=%b exp=%b", $time, underrun, m_under);
    end
    checks++;
    if (underrun_count !== CW'(m_count)) begin
      errors++; $display("FAIL underrun_count t=%0t got=%0d exp=%0d", $time, underrun_count, m_count);
    end
    checks++;
    if (audio_out !== m_audio) begin
      errors++; $display("FAIL audio_out t=%0t got=%h exp=%h", $time, audio_out, m_audio);
    end
    checks++;
    if ({ub_timecode, ub_midi, ub_smux} !== m_ub) begin
      errors++; $display("FAIL ub t=%0t got=%b exp=%b", $time, {ub_timecode, ub_midi, ub_smux}, m_ub);
    end
  endtask

  task automatic idle(input bit en);
    step(en, 1'b0, 0, '0, cur_ub);
  endtask

  // Idle-run until start is seen; n = cycles taken, -1 if the bound expires
  task automatic run_until_start(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      idle(1'b1);
      if (start === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_chan = '0; s_data = '0;
    timecode = 1'b0; midi = 1'b0; smux = 1'b0; cur_ub = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({start, underrun, s_ready, ub_timecode, ub_midi, ub_smux} !== 6'b0 ||
        underrun_count !== '0 || audio_out !== '0) begin
      errors++; $display("FAIL reset_state start=%b und=%b rdy=%b cnt=%0d audio=%h",
                         start, underrun, s_ready, underrun_count, audio_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n;
    int gap;
    run_until_start(2 * FC, n);   // first frame underruns
    for (int c = 0; c < NCH; c++) step(1'b1, 1'b1, c, SW'($urandom), cur_ub);
    run_until_start(2 * FC, n);
    // Assert reset with start high and non-zero outputs held
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({start, underrun, s_ready} !== 3'b0 || underrun_count !== '0 || audio_out !== '0) begin
      errors++; $display("FAIL reset_async start=%b und=%b rdy=%b cnt=%0d audio=%h",
                         start, underrun, s_ready, underrun_count, audio_out);
    end
    model_reset();
    @(negedge clk);
    enable = 1'b0; reset_n = 1'b1;
    run_until_start(3 * FC, n);
    checks++;
    if (n != FC) begin
      errors++; $display("FAIL first_start_latency got=%0d exp=%0d", n, FC);
    end
    run_until_start(3 * FC, gap);
    checks++;
    if (gap != FC) begin
      errors++; $display("FAIL start_spacing got=%0d exp=%0d", gap, FC);
    end
  endtask

  task automatic test_full_frame();
    int n;
    idle(1'b0);
    for (int c = 0; c < NCH; c++) step(1'b1, 1'b1, c, SW'(c + 1), cur_ub);
    run_until_start(FC, n);
    checks++;
    if (n != FC - NCH) begin
      errors++; $display("FAIL full_start_cycle got=%0d exp=%0d", n + NCH, FC);
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (audio_out[c] !== SW'(c + 1)) begin
        errors++; $display("FAIL full_audio ch=%0d got=%h exp=%h", c, audio_out[c], c + 1);
      end
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL full_underrun got=%b exp=0", underrun);
    end
    run_until_start(2 * FC, n);
    checks++;
    if (n != FC) begin
      errors++; $display("FAIL full_next_start got=%0d exp=%0d", n, FC);
    end
  endtask

  task automatic test_underrun();
    int n;
    int prev;
    logic [SW-1:0] vals [NCH];
    idle(1'b0);
    for (int c = 0; c < NCH; c++) vals[c] = SW'($urandom);
    for (int c = 0; c < NCH - 1; c++) step(1'b1, 1'b1, c, vals[c], cur_ub);
    prev = int'(underrun_count);
    run_until_start(FC, n);
    checks++;
    if (underrun !== 1'b1 || audio_out !== '0) begin
      errors++; $display("FAIL underrun_mute und=%b audio=%h", underrun, audio_out);
    end
    checks++;
    if (int'(underrun_count) != ((prev < CMAX) ? prev + 1 : CMAX)) begin
      errors++; $display("FAIL underrun_inc got=%0d prev=%0d", underrun_count, prev);
    end
    repeat (FC / 2) idle(1'b1);
    step(1'b1, 1'b1, NCH - 1, vals[NCH-1], cur_ub);
    run_until_start(FC, n);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (audio_out[c] !== vals[c]) begin
        errors++; $display("FAIL retained_audio ch=%0d got=%h exp=%h", c, audio_out[c], vals[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [SW-1:0] v3;
    logic [SW-1:0] b2;
    idle(1'b0);
    step(1'b1, 1'b1, 2, 24'hAAAAAA, cur_ub);
    v3 = 24'h333333;
    b2 = 24'h5A5A5A;
    for (int c = 0; c < NCH - 1; c++)
      if (c != 2) step(1'b1, 1'b1, c, (c == 3) ? v3 : SW'($urandom), cur_ub);
    step(1'b1, 1'b1, 2, b2, cur_ub);
    step(1'b1, 1'b1, NCH - 1, SW'($urandom), cur_ub);
    // Buffer full: hold a pending write on ch3 until the boundary
    n = 0;
    while (start !== 1'b1 && n < 2 * FC) begin
      step(1'b1, 1'b1, 3, 24'hDEAD00, cur_ub);
      n++;
    end
    checks++;
    if (audio_out[2] !== b2 || audio_out[3] !== v3) begin
      errors++; $display("FAIL backpressure ch2=%h exp=%h ch3=%h exp=%h",
                         audio_out[2], b2, audio_out[3], v3);
    end
  endtask

  task automatic test_user_bits();
    int n;
    idle(1'b0);
    cur_ub = 3'b101;
    run_until_start(2 * FC, n);
    checks++;
    if ({ub_timecode, ub_midi, ub_smux} !== 3'b101) begin
      errors++; $display("FAIL ub_capture got=%b exp=101", {ub_timecode, ub_midi, ub_smux});
    end
    cur_ub = 3'b010;
    run_until_start(2 * FC, n);
    checks++;
    if ({ub_timecode, ub_midi, ub_smux} !== 3'b010) begin
      errors++; $display("FAIL ub_recapture got=%b exp=010", {ub_timecode, ub_midi, ub_smux});
    end
  endtask

  task automatic test_saturation();
    idle(1'b0);
    repeat ((CMAX + 5) * FC) idle(1'b1);
    checks++;
    if (start !== 1'b1 || underrun !== 1'b1 || underrun_count !== CW'(CMAX)) begin
      errors++; $display("FAIL saturation start=%b und=%b cnt=%0d exp=%0d",
                         start, underrun, underrun_count, CMAX);
    end
  endtask

  task automatic test_random();
    bit en;
    en = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 9) == 0) cur_ub = 3'($urandom);
      step(en, ($urandom_range(0, 99) < 45), int'($urandom_range(0, NCH - 1)),
           SW'($urandom), cur_ub);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_full_frame();
    test_underrun();
    test_back_to_back();
    test_user_bits();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
